// File: rtl/watch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : watch_pkg
// Description : Shared FSM encoding and helpers for the button debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
package watch_pkg;

    localparam logic [1:0] c_IDLE         = 2'd0;
    localparam logic [1:0] c_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] c_PRESSED      = 2'd2;
    localparam logic [1:0] c_RELEASE_WAIT = 2'd3;

    typedef enum logic [1:0] {
        IDLE         = c_IDLE,
        PRESS_WAIT   = c_PRESS_WAIT,
        PRESSED      = c_PRESSED,
        RELEASE_WAIT = c_RELEASE_WAIT
    } state_t;

    // The debounced level is high exactly in these two states.
    function automatic logic is_high_state(input state_t s);
        return (s == PRESSED) || (s == RELEASE_WAIT);
    endfunction

endpackage : watch_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for a single asynchronous level.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : button_debouncer
// Description : Debounces a raw button and generates long-press and
//               auto-repeat pulses while the button stays held.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer
    import watch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int LONG_CYCLES     = 100000000,
    parameter int REPEAT_CYCLES   = 20000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_in,
    output logic btn_stable,
    output logic long_press,
    output logic rpt_pulse
);

    localparam int c_DEB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int c_HOLD_W = $clog2(LONG_CYCLES) + 1;
    localparam int c_RPT_W  = $clog2(REPEAT_CYCLES) + 1;

    localparam logic [c_DEB_W-1:0]  c_DEB_MAX  = c_DEB_W'(DEBOUNCE_CYCLES);
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(LONG_CYCLES);
    localparam logic [c_HOLD_W-1:0] c_HOLD_PRE = c_HOLD_W'(LONG_CYCLES - 1);
    localparam logic [c_RPT_W-1:0]  c_RPT_MAX  = c_RPT_W'(REPEAT_CYCLES);

    logic w_sync;

    sync_2ff u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (btn_in),
        .q       (w_sync)
    );

    state_t              r_state;
    logic [c_DEB_W-1:0]  r_deb_cnt;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [c_RPT_W-1:0]  r_rpt_cnt;
    logic                r_btn_stable;
    logic                r_long_press;
    logic                r_rpt_pulse;

    logic [c_DEB_W-1:0]  w_deb_inc;
    logic                w_deb_done;
    logic                w_hold_sat;
    logic [c_HOLD_W-1:0] w_hold_next;
    logic [c_RPT_W-1:0]  w_rpt_inc;
    logic [c_RPT_W-1:0]  w_rpt_next;
    logic                w_lp_next;
    logic                w_rp_next;

    always_comb begin
        w_deb_inc  = (r_deb_cnt == c_DEB_MAX) ? r_deb_cnt : r_deb_cnt + 1'b1;
        w_deb_done = (w_deb_inc == c_DEB_MAX);

        // The hold counter parks at LONG_CYCLES; from then on the repeat
        // counter takes over, so long_press cannot fire twice per press.
        w_hold_sat  = (r_hold_cnt == c_HOLD_MAX);
        w_hold_next = w_hold_sat ? r_hold_cnt : r_hold_cnt + 1'b1;
        w_lp_next   = (r_hold_cnt == c_HOLD_PRE);

        w_rpt_inc  = r_rpt_cnt + 1'b1;
        w_rp_next  = w_hold_sat && (w_rpt_inc == c_RPT_MAX);
        w_rpt_next = '0;
        if (w_hold_sat && !w_rp_next) begin
            w_rpt_next = w_rpt_inc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_deb_cnt    <= '0;
            r_hold_cnt   <= '0;
            r_rpt_cnt    <= '0;
            r_btn_stable <= 1'b0;
            r_long_press <= 1'b0;
            r_rpt_pulse  <= 1'b0;
        end else begin
            r_long_press <= 1'b0;
            r_rpt_pulse  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_deb_cnt    <= '0;
                    r_hold_cnt   <= '0;
                    r_rpt_cnt    <= '0;
                    r_btn_stable <= 1'b0;
                    if (w_sync) begin
                        r_state <= PRESS_WAIT;
                    end
                end
                PRESS_WAIT: begin
                    r_hold_cnt <= '0;
                    r_rpt_cnt  <= '0;
                    if (!w_sync) begin
                        r_state   <= IDLE;
                        r_deb_cnt <= '0;
                    end else if (w_deb_done) begin
                        r_state      <= PRESSED;
                        r_deb_cnt    <= '0;
                        r_btn_stable <= 1'b1;
                    end else begin
                        r_deb_cnt <= w_deb_inc;
                    end
                end
                PRESSED: begin
                    r_hold_cnt   <= w_hold_next;
                    r_rpt_cnt    <= w_rpt_next;
                    r_long_press <= w_lp_next;
                    r_rpt_pulse  <= w_rp_next;
                    r_deb_cnt    <= '0;
                    if (!w_sync) begin
                        r_state <= RELEASE_WAIT;
                    end
                end
                RELEASE_WAIT: begin
                    if (w_sync) begin
                        r_state      <= PRESSED;
                        r_deb_cnt    <= '0;
                        r_hold_cnt   <= w_hold_next;
                        r_rpt_cnt    <= w_rpt_next;
                        r_long_press <= w_lp_next;
                        r_rpt_pulse  <= w_rp_next;
                    end else if (w_deb_done) begin
                        r_state      <= IDLE;
                        r_deb_cnt    <= '0;
                        r_hold_cnt   <= '0;
                        r_rpt_cnt    <= '0;
                        r_btn_stable <= 1'b0;
                    end else begin
                        r_deb_cnt    <= w_deb_inc;
                        r_hold_cnt   <= w_hold_next;
                        r_rpt_cnt    <= w_rpt_next;
                        r_long_press <= w_lp_next;
                        r_rpt_pulse  <= w_rp_next;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_deb_cnt    <= '0;
                    r_hold_cnt   <= '0;
                    r_rpt_cnt    <= '0;
                    r_btn_stable <= 1'b0;
                end
            endcase
        end
    end

    assign btn_stable = r_btn_stable;
    assign long_press = r_long_press;
    assign rpt_pulse  = r_rpt_pulse;

endmodule : button_debouncer
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_debouncer
// Description : Self-checking bench for button_debouncer (D=4, L=20, R=5).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debouncer;

    localparam int c_D = 4;
    localparam int c_L = 20;
    localparam int c_R = 5;

    logic clk;
    logic reset_n;
    logic btn_in;
    logic btn_stable;
    logic long_press;
    logic rpt_pulse;

    int n_checks;
    int n_errors;

    button_debouncer #(
        .DEBOUNCE_CYCLES (c_D),
        .LONG_CYCLES     (c_L),
        .REPEAT_CYCLES   (c_R)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_in     (btn_in),
        .btn_stable (btn_stable),
        .long_press (long_press),
        .rpt_pulse  (rpt_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the FSM sees the raw sample two edges late; the level flips
    // after D+1 consecutive opposite samples; pulses follow from hold time.
    logic m_d1, m_d2, m_stable, m_lp, m_rp;
    int   m_run, m_hold;

    task automatic m_reset();
        m_d1 = 1'b0; m_d2 = 1'b0; m_stable = 1'b0;
        m_lp = 1'b0; m_rp = 1'b0; m_run = 0; m_hold = 0;
    endtask

    task automatic m_edge(input logic b);
        logic seen;
        seen = m_d2;
        m_d2 = m_d1;
        m_d1 = b;
        m_lp = 1'b0;
        m_rp = 1'b0;
        if (seen != m_stable) m_run++;
        else m_run = 0;
        if (m_run == c_D + 1) begin
            m_stable = ~m_stable;
            m_run    = 0;
            m_hold   = 0;
        end else if (m_stable) begin
            m_hold++;
            m_lp = (m_hold == c_L);
            m_rp = (m_hold > c_L) && (((m_hold - c_L) % c_R) == 0);
        end
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic b);
        @(negedge clk);
        btn_in = b;
        @(posedge clk);
        m_edge(b);
        #1;
        chk("model_stable", btn_stable, m_stable);
        chk("model_long", long_press, m_lp);
        chk("model_rpt", rpt_pulse, m_rp);
        chk("pulse_overlap", long_press & rpt_pulse, 1'b0);
        chk("pulse_unstable", (long_press | rpt_pulse) & ~btn_stable, 1'b0);
    endtask

    task automatic step_exp(input string name, input logic b,
                            input logic es, input logic el, input logic er);
        step(b);
        chk({name, "_stable"}, btn_stable, es);
        chk({name, "_long"}, long_press, el);
        chk({name, "_rpt"}, rpt_pulse, er);
    endtask

    // Called just after a step: asserts reset mid-cycle, holds it, then
    // releases it before the next falling edge so no sampling edge is missed.
    task automatic do_reset(input int hold_cycles);
        #1;
        reset_n = 1'b0;
        #1;
        m_reset();
        chk("rst_stable", btn_stable, 1'b0);
        chk("rst_long", long_press, 1'b0);
        chk("rst_rpt", rpt_pulse, 1'b0);
        repeat (hold_cycles) @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic btn;
        logic stable;
        logic lp;
        logic rp;
    } vec_t;

    vec_t vecs[25];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, time %0t expected below 2000000", $time);
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;

        // Clean press and release, then a 3-clock glitch.
        for (int i = 0; i < 8; i++) vecs[i] = '{1'b1, (i >= 6), 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) vecs[8 + i] = '{1'b0, (i < 6), 1'b0, 1'b0};
        for (int i = 0; i < 9; i++) vecs[16 + i] = '{(i < 3), 1'b0, 1'b0, 1'b0};

        reset_n = 1'b0;
        btn_in  = 1'b0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("init_stable", btn_stable, 1'b0);
        chk("init_long", long_press, 1'b0);
        chk("init_rpt", rpt_pulse, 1'b0);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            step_exp("table", vecs[i].btn, vecs[i].stable, vecs[i].lp, vecs[i].rp);
        end

        // Long hold: long_press at hold 20, repeats at 25, 30, 35, 40.
        for (int i = 0; i < 50; i++) begin
            step_exp("long_hold", 1'b1, (i >= 6), (i == 26),
                     (i == 31) || (i == 36) || (i == 41) || (i == 46));
        end
        repeat (10) step(1'b0);
        chk("long_released", btn_stable, 1'b0);

        // Two-clock release bounce must not restart the hold count.
        for (int i = 0; i < 34; i++) begin
            step_exp("bounce", !((i == 12) || (i == 13)), (i >= 6), (i == 26), (i == 31));
        end
        repeat (10) step(1'b0);

        // Reset at hold count 10 with the button still held.
        for (int i = 0; i < 17; i++) step_exp("pre_reset", 1'b1, (i >= 6), 1'b0, 1'b0);
        do_reset(2);
        for (int i = 0; i < 30; i++) begin
            step_exp("post_reset", 1'b1, (i >= 6), (i == 26), 1'b0);
        end
        repeat (10) step(1'b0);

        // Random bursts of varying length, with occasional resets.
        begin
            logic lvl;
            int   len;
            lvl = 1'b0;
            for (int burst = 0; burst < 120; burst++) begin
                lvl = ~lvl;
                if ($urandom_range(0, 4) == 0) len = $urandom_range(15, 45);
                else len = $urandom_range(1, 8);
                for (int k = 0; k < len; k++) step(lvl);
                if ($urandom_range(0, 19) == 0) do_reset($urandom_range(1, 3));
            end
        end
        repeat (12) step(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_button_debouncer
`default_nettype wire
